// File: rtl/hamming_enc.sv
// Hamming(21,16) encoder: two-stage valid/ready pipeline with full backpressure
// and an optional periodic single-bit error injector for exercising the decoder.
module hamming_enc #(
  parameter int INJECT_PERIOD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] iData,
  input  logic        iValid,
  output logic        oReady,
  output logic [20:0] oData,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iInjEn,
  output logic        oInjected
);

  localparam logic [7:0]  LAST_WORD = 8'(INJECT_PERIOD - 1);
  localparam logic [4:0]  LAST_POS  = 5'd20;

  // Parity coverage masks: index i is Hamming position i+1.
  localparam logic [20:0] P0_MASK  = 21'h155554;
  localparam logic [20:0] P1_MASK  = 21'h066664;
  localparam logic [20:0] P3_MASK  = 21'h187870;
  localparam logic [20:0] P7_MASK  = 21'h007F00;
  localparam logic [20:0] P15_MASK = 21'h1F0000;

  logic        s1_valid;
  logic [15:0] s1_data;
  logic        s1_load;
  logic        s2_load;
  logic [7:0]  cnt;
  logic [4:0]  pos;
  logic        inject;
  logic [20:0] placed;
  logic [20:0] cw;
  logic [20:0] inj_mask;

  assign s2_load = s1_valid && (!oValid || iReady);
  assign s1_load = iValid && oReady;
  // S1 frees up in the same cycle it hands its word to S2, so a drain and a refill coexist.
  assign oReady  = !rst && (!s1_valid || s2_load);

  assign placed = {s1_data[15:11], 1'b0, s1_data[10:4], 1'b0, s1_data[3:1], 1'b0, s1_data[0], 2'b00};
  assign cw     = placed | {5'b0, ^(placed & P15_MASK), 7'b0, ^(placed & P7_MASK), 3'b0,
                            ^(placed & P3_MASK), 1'b0, ^(placed & P1_MASK), ^(placed & P0_MASK)};

  assign inject   = iInjEn && (cnt == LAST_WORD);
  assign inj_mask = inject ? (21'd1 << pos) : 21'd0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_data  <= iData;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oValid    <= 1'b0;
      oData     <= '0;
      oInjected <= 1'b0;
    end else if (s2_load) begin
      oValid    <= 1'b1;
      oData     <= cw ^ inj_mask;
      oInjected <= inject;
    end else if (iReady) begin
      oValid    <= 1'b0;
    end
  end

  // pos is deliberately kept while injection is disabled so the sweep resumes where it stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pos <= '0;
    end else if (!iInjEn) begin
      cnt <= '0;
    end else if (s2_load) begin
      if (cnt == LAST_WORD) begin
        cnt <= '0;
        pos <= (pos == LAST_POS) ? 5'd0 : pos + 5'd1;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_enc.sv
// Self-checking bench for hamming_enc: fixed vectors, random stream against a
// positional Hamming model, backpressure, periodic injection and mid-run reset.
module tb_hamming_enc;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iData;
  logic        iValid;
  logic        oReady;
  logic [20:0] oData;
  logic        oValid;
  logic        iReady;
  logic        iInjEn;
  logic        oInjected;

  int vectors     = 0;
  int miscompares = 0;

  logic        inf, outf, ov, oinj;
  logic [20:0] od;

  typedef struct {
    logic [15:0] data;
    logic [20:0] cw;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  hamming_enc #(.INJECT_PERIOD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .iData     (iData),
    .iValid    (iValid),
    .oReady    (oReady),
    .oData     (oData),
    .oValid    (oValid),
    .iReady    (iReady),
    .iInjEn    (iInjEn),
    .oInjected (oInjected)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Data fills the non-power-of-two positions in order; each parity bit 2^b
  // takes bit b of the syndrome of the data so the full word has syndrome 0.
  function automatic logic [20:0] ref_encode(input logic [15:0] d);
    logic [20:0] c;
    int k;
    int s;
    c = '0;
    k = 0;
    s = 0;
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    for (int p = 1; p <= 21; p++)
      if (c[p-1]) s = s ^ p;
    for (int b = 0; b < 5; b++) c[(1 << b) - 1] = s[b];
    return c;
  endfunction

  function automatic logic [15:0] ref_decode(input logic [20:0] cw_in);
    logic [20:0] c;
    logic [15:0] d;
    int k;
    int s;
    c = cw_in;
    s = 0;
    for (int p = 1; p <= 21; p++)
      if (c[p-1]) s = s ^ p;
    if (s != 0 && s <= 21) c[s-1] = ~c[s-1];
    k = 0;
    d = '0;
    for (int p = 1; p <= 21; p++)
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    return d;
  endfunction

  // Called at posedge+1: drive inputs, observe settled outputs, advance one clock.
  task automatic cycle(input logic v, input logic [15:0] d, input logic rdy);
    iValid = v;
    iData  = d;
    iReady = rdy;
    #1;
    inf  = iValid && oReady;
    outf = oValid && iReady;
    ov   = oValid;
    od   = oData;
    oinj = oInjected;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    iValid = 1'b0;
    iReady = 1'b0;
    iInjEn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv, n, got, accepted, pexp;
    logic [15:0] exp_q[$];
    logic [15:0] cur_d, e;
    logic        cur_v, hold_pending;
    logic [20:0] held;

    tbl[0] = '{16'h0001, 21'h000007};
    tbl[1] = '{16'hFFFF, 21'h1FFFFE};
    tbl[2] = '{16'h0000, 21'h000000};
    tbl[3] = '{16'h8000, 21'h108009};
    tbl[4] = '{16'h0800, 21'h018001};
    tbl[5] = '{16'h0010, 21'h000181};

    // Reset state and first-word latency.
    rst    = 1'b1;
    iValid = 1'b1;
    iData  = 16'h0001;
    iReady = 1'b1;
    iInjEn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ovalid", oValid, 0);
    check("rst_odata", oData, 0);
    check("rst_oinj", oInjected, 0);
    check("rst_oready", oReady, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_oready", oReady, 1);
    @(posedge clk);
    #1;
    check("lat_edge_k", oValid, 0);
    iValid = 1'b0;
    @(posedge clk);
    #1;
    check("lat_ovalid", oValid, 1);
    check("lat_odata", oData, 21'h000007);
    check("lat_oinj", oInjected, 0);
    cycle(1'b0, 16'h0, 1'b1);

    // Table vectors, back to back.
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 40 && rcv < 6; c++) begin
      e = (sent < 6) ? tbl[sent].data : 16'h0;
      cycle(sent < 6, e, 1'b1);
      if (outf) begin
        check("table_cw", od, tbl[rcv].cw);
        check("table_inj", oinj, 0);
        rcv++;
      end
      if (inf) sent++;
    end
    check("table_count", rcv, 6);

    // Random stream with random backpressure.
    got = 0;
    accepted = 0;
    cur_v = 1'b0;
    cur_d = '0;
    hold_pending = 1'b0;
    held = '0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      if (!cur_v && accepted < 1000 && $urandom_range(0, 3) != 0) begin
        cur_v = 1'b1;
        cur_d = 16'($urandom);
      end
      cycle(cur_v, cur_d, 1'($urandom_range(0, 1)));
      if (hold_pending) check("stream_hold", {ov, od}, {1'b1, held});
      hold_pending = ov && !outf;
      held = od;
      if (outf) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("stream_cw", od, ref_encode(e));
          check("stream_inj", oinj, 0);
          check("stream_decode", ref_decode(od), e);
        end
        got++;
      end
      if (inf) begin
        exp_q.push_back(cur_d);
        accepted++;
        cur_v = 1'b0;
      end
    end
    check("stream_count", got, 1000);
    check("stream_leftover", exp_q.size(), 0);

    // Backpressure: two words buffered, third refused, then ordered drain.
    cycle(1'b1, 16'h1234, 1'b0);
    check("bp_accept_a", inf, 1);
    cycle(1'b1, 16'hABCD, 1'b0);
    check("bp_accept_b", inf, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h5A5A, 1'b0);
      check("bp_refuse_c", inf, 0);
      check("bp_hold_a", {ov, od}, {1'b1, ref_encode(16'h1234)});
    end
    cycle(1'b1, 16'h5A5A, 1'b1);
    check("bp_drain_a", {outf, od}, {1'b1, ref_encode(16'h1234)});
    check("bp_refill_c", inf, 1);
    cycle(1'b0, 16'h0, 1'b1);
    check("bp_drain_b", {outf, od}, {1'b1, ref_encode(16'hABCD)});
    cycle(1'b0, 16'h0, 1'b1);
    check("bp_drain_c", {outf, od}, {1'b1, ref_encode(16'h5A5A)});
    cycle(1'b0, 16'h0, 1'b1);
    check("bp_empty", outf, 0);

    // Periodic injection sweep, including pos wrap.
    do_reset();
    iInjEn = 1'b1;
    n = 0;
    for (int c = 0; c < 400 && n < 176; c++) begin
      cycle(1'b1, 16'h0, 1'b1);
      if (outf) begin
        n++;
        pexp = (n / P - 1) % 21;
        if (n % P == 0) begin
          check("inj_flag", oinj, 1);
          check("inj_cw", od, 21'd1 << pexp);
        end else begin
          check("inj_flag", oinj, 0);
          check("inj_cw", od, 0);
        end
        check("inj_decode", ref_decode(od), 0);
      end
    end
    check("inj_count", n, 176);
    repeat (3) cycle(1'b0, 16'h0, 1'b1);

    // Reset with both stages full and iValid high.
    cycle(1'b1, 16'h1111, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0);
    iValid = 1'b1;
    iData  = 16'h3333;
    #1;
    check("full_ovalid", oValid, 1);
    check("full_oready", oReady, 0);
    rst = 1'b1;
    #1;
    check("arst_ovalid", oValid, 0);
    check("arst_oready", oReady, 0);
    check("arst_odata", oData, 0);
    check("arst_oinj", oInjected, 0);
    iReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold", {oValid, oReady}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    iValid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0, 1'b1);
      check("no_stale", ov, 0);
    end
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      cycle(1'b1, 16'h0, 1'b1);
      if (outf) begin
        n++;
        check("restart_flag", oinj, n == 8);
        check("restart_cw", od, (n == 8) ? 21'd1 : 21'd0);
      end
    end
    check("restart_count", n, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
